pa_spsram_param: RTL and testbench
==================================

# pa_spsram_param

Parametrised single-port SRAM model for FPGA builds, generalising the fixed-size LSU/IFU SRAM wrappers. Adds configurable depth/width, configurable write-mask granularity, an optional output register stage, and a built-in clear sequencer. The clear sequencer writes a known value to every entry after reset or on request, so tag and valid arrays need no external flush logic. It sits under the per-array wrappers, such as the 512x38 tag arrays, in place of the fixed-geometry FPGA memory.

## Interface
**Parameters**
- ADDR_WIDTH, 9: address bits; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 38: data bits.
- WE_WIDTH, 38: write-mask bits. Must divide DATA_WIDTH. Each WEN bit covers DATA_WIDTH/WE_WIDTH adjacent data bits; WEN[i] covers D[i*G +: G], where G = DATA_WIDTH/WE_WIDTH.
- OUT_REG, 0: 1 adds an output pipeline register, giving read latency 2.
- INIT_EN, 1: 1 enables the clear sweep after reset; 0 makes the block ready immediately after reset.
- INIT_VAL, 0: DATA_WIDTH-bit value written by the sweep.

**Ports**
- CLK, in, 1: clock. All state updates on the rising edge.
- RST, in, 1: asynchronous, active-high reset.
- CEN, in, 1: chip enable, active low.
- GWEN, in, 1: global write enable, active low. 0 = write, 1 = read.
- WEN, in, WE_WIDTH: per-group write enable, active low.
- A, in, ADDR_WIDTH: address.
- D, in, DATA_WIDTH: write data.
- INIT_REQ, in, 1: single-cycle request to re-run the clear sweep.
- Q, out, DATA_WIDTH: read data.
- INIT_BUSY, out, 1: high while the sweep owns the array.

## Operation
- **Access** is accepted when CEN=0 and INIT_BUSY=0.
  - Write: GWEN=0. Groups with WEN[i]=0 are written; groups with WEN[i]=1 keep their old contents.
  - Read: GWEN=1. Returns mem[A].
- **Q behaviour:** Q updates only on accepted reads. Writes, idle cycles and ignored accesses leave Q unchanged; there is no write-through.
- **Busy:** accesses while INIT_BUSY=1 are ignored and have no side effects on the array or Q.
- **Sweep FSM** has states INIT and READY.
  - RST: if INIT_EN=1, state=INIT and cnt=0; otherwise state=READY.
  - INIT: each cycle writes INIT_VAL to mem[cnt] and increments cnt. When cnt=DEPTH-1 is written, cnt wraps to 0 and the next state is READY.
  - READY with INIT_REQ=1: next state is INIT and cnt=0. The access presented in that same cycle is still performed normally.
  - INIT_REQ during INIT is ignored; it neither restarts nor extends the sweep.
  - INIT_REQ when INIT_EN=0 is ignored.
- **INIT_BUSY** = (state == INIT). It is registered, not decoded from inputs.
- **Reset:** RST asserted mid-sweep restarts the sweep from cnt=0. RST asserted mid-read leaves the in-flight read undelivered and sets Q to 0.
- **Reset values:** Q=0; output register (if present) = 0; INIT_BUSY = INIT_EN. Array contents are not reset; only the sweep clears them.

## Timing
- Read latency, OUT_REG=0: read accepted at edge N → Q valid after edge N and held from then on.
- Read latency, OUT_REG=1: Q valid after edge N+1. Back-to-back reads yield one result per cycle.
- Write followed by a read of the same address on the next edge returns the new data.
- Sweep length: after RST falls, INIT_BUSY stays high for exactly DEPTH rising edges. The first access is accepted on the edge where INIT_BUSY is sampled low.
- Re-init: INIT_REQ sampled at edge N → INIT_BUSY high from after edge N, for DEPTH edges.
- Read issued at edge N, then INIT_REQ at edge N+1 with OUT_REG=1: the pipelined result still appears on Q. The output stage is never flushed except by RST.

## Structure
- **Shared package** holds:
  - the sweep state encoding (INIT, READY);
  - a localparam function for group size G = DATA_WIDTH/WE_WIDTH;
  - an elaboration-time check that fails when DATA_WIDTH % WE_WIDTH != 0.
- **Sub-module pa_spsram_init_ctrl** contains the state register, the ADDR_WIDTH-bit counter, INIT_BUSY, and the sweep-address/write-enable muxes.
- **Top level** contains the memory array (a behavioural reg array, inferred as block RAM), the per-group mask expansion, the Q register, and the optional output stage.

## Test plan
- Default params, reset released: INIT_BUSY high for 512 cycles. Afterwards, reads of addresses 0, 255 and 511 return 0 at latency 1.
- Write A=9'h05, D=38'h3F_FFFF_FFFF, WEN all 0. Then write D=0 with WEN[7:0]=0 and the rest 1. Read back → 38'h3F_FFFF_FF00.
- WE_WIDTH=2, DATA_WIDTH=38, OUT_REG=1. Write 0, then write all-ones with WEN=2'b10. Read → low 19 bits set, high 19 bits clear, appearing 2 cycles after the read.
- Read A=3 returning 38'h1234. Then INIT_REQ pulse; a write attempt during busy is ignored. Q holds 38'h1234 throughout. After 512 cycles, A=3 reads 0.
- Assert RST at sweep count 100: Q=0 immediately, and the sweep restarts. INIT_BUSY stays high for a full 512 cycles after release.
- INIT_EN=0: INIT_BUSY=0 out of reset. An INIT_REQ pulse has no effect, and a write/read on the first cycle succeeds.

Source files
------------

// File: rtl/pa_spsram_param_pkg.sv
// pa_spsram_param_pkg
// Shared definitions for the parametrised single-port SRAM:
//   - sweep FSM state encoding (INIT / READY)
//   - group-size helper G = DATA_WIDTH / WE_WIDTH
//   - mask_ok(): elaboration-time legality check of the mask geometry
package pa_spsram_param_pkg;

  localparam logic [0:0] ST_READY = 1'b0;
  localparam logic [0:0] ST_INIT  = 1'b1;

  function automatic int grp_size(input int dw, input int ww);
    return dw / ww;
  endfunction

  // True when every write-mask bit covers a whole, equal slice of the word.
  function automatic bit mask_ok(input int dw, input int ww);
    return (ww > 0) && ((dw % ww) == 0);
  endfunction

endpackage

// File: rtl/pa_spsram_param_if.sv
// pa_spsram_param_if
// Access bus of the single-port SRAM.
//   CEN/GWEN/WEN  : chip enable, global write enable, per-group write enable (all active low)
//   A/D           : address, write data
//   INIT_REQ      : one-cycle request to re-run the clear sweep
//   Q/INIT_BUSY   : read data, sweep-owns-array flag
// master = requester side, slave = memory side.
interface pa_spsram_param_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 38,
  parameter int WE_WIDTH   = 38
);
  logic                  CEN;
  logic                  GWEN;
  logic [WE_WIDTH-1:0]   WEN;
  logic [ADDR_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] D;
  logic                  INIT_REQ;
  logic [DATA_WIDTH-1:0] Q;
  logic                  INIT_BUSY;

  modport master (output CEN, GWEN, WEN, A, D, INIT_REQ, input  Q, INIT_BUSY);
  modport slave  (input  CEN, GWEN, WEN, A, D, INIT_REQ, output Q, INIT_BUSY);
endinterface

// File: rtl/pa_spsram_param_init_ctrl.sv
// pa_spsram_init_ctrl
// Clear-sweep sequencer plus the array port mux.
//   CLK, RST          : clock, async active-high reset
//   i_cen..i_init_req : user access (active-low enables as on the bus)
//   o_busy            : registered INIT_BUSY
//   o_mem_we/o_grp_we : array write strobe and active-high per-group enables
//   o_addr/o_din      : array address / write data (sweep or user)
//   o_rd_en           : accepted user read
module pa_spsram_init_ctrl
  import pa_spsram_param_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    DATA_WIDTH = 38,
  parameter int                    WE_WIDTH   = 38,
  parameter int                    INIT_EN    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_cen,
  input  logic                  i_gwen,
  input  logic [WE_WIDTH-1:0]   i_wen,
  input  logic [ADDR_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_d,
  input  logic                  i_init_req,
  output logic                  o_busy,
  output logic                  o_mem_we,
  output logic [WE_WIDTH-1:0]   o_grp_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_din,
  output logic                  o_rd_en
);
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  w_busy;
  logic                  w_acc;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= (INIT_EN != 0) ? ST_INIT : ST_READY;
      r_cnt   <= '0;
    end else if (r_state == ST_INIT) begin
      // INIT_REQ is deliberately not looked at here: a running sweep is never restarted.
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST) r_state <= ST_READY;
    end else if (i_init_req && (INIT_EN != 0)) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end
  end

  assign w_busy   = (r_state == ST_INIT);
  assign w_acc    = !i_cen && !w_busy;

  assign o_busy   = w_busy;
  assign o_mem_we = w_busy || (w_acc && !i_gwen);
  assign o_grp_we = w_busy ? '1 : ~i_wen;
  assign o_addr   = w_busy ? r_cnt : i_a;
  assign o_din    = w_busy ? INIT_VAL : i_d;
  assign o_rd_en  = w_acc && i_gwen;
endmodule

// File: rtl/pa_spsram_param.sv
// pa_spsram_param
// Parametrised single-port SRAM with group write mask, optional output
// register (read latency 1 or 2) and built-in clear sweep.
//   CLK, RST : clock, async active-high reset (clears Q path, restarts sweep)
//   bus      : pa_spsram_param_if.slave access port
module pa_spsram_param
  import pa_spsram_param_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    DATA_WIDTH = 38,
  parameter int                    WE_WIDTH   = 38,
  parameter int                    OUT_REG    = 0,
  parameter int                    INIT_EN    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic               CLK,
  input  logic               RST,
  pa_spsram_param_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int G     = grp_size(DATA_WIDTH, WE_WIDTH);

  if (!mask_ok(DATA_WIDTH, WE_WIDTH)) begin : g_bad_mask
    $error("pa_spsram_param: WE_WIDTH must divide DATA_WIDTH");
  end

  logic                  w_mem_we;
  logic [WE_WIDTH-1:0]   w_grp_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_din;
  logic                  w_rd_en;
  logic                  w_busy;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_q;

  pa_spsram_init_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .WE_WIDTH   (WE_WIDTH),
    .INIT_EN    (INIT_EN),
    .INIT_VAL   (INIT_VAL)
  ) u_ctrl (
    .CLK        (CLK),
    .RST        (RST),
    .i_cen      (bus.CEN),
    .i_gwen     (bus.GWEN),
    .i_wen      (bus.WEN),
    .i_a        (bus.A),
    .i_d        (bus.D),
    .i_init_req (bus.INIT_REQ),
    .o_busy     (w_busy),
    .o_mem_we   (w_mem_we),
    .o_grp_we   (w_grp_we),
    .o_addr     (w_addr),
    .o_din      (w_din),
    .o_rd_en    (w_rd_en)
  );

  // Array has no reset; contents are defined only by writes and the sweep.
  // Each enabled group is written as a G-bit slice so tools map it to BRAM byte enables.
  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      for (int g = 0; g < WE_WIDTH; g++) begin
        if (w_grp_we[g]) r_mem[w_addr][g*G +: G] <= w_din[g*G +: G];
      end
    end
  end

  // Q moves only on an accepted read; writes and busy cycles hold it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          r_q <= '0;
    else if (w_rd_en) r_q <= r_mem[w_addr];
  end

  if (OUT_REG != 0) begin : g_oreg
    // Free-running copy of r_q: changes only a cycle after r_q does, and is
    // never flushed by a re-init sweep.
    logic [DATA_WIDTH-1:0] r_q2;
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_q2 <= '0;
      else     r_q2 <= r_q;
    end
    assign bus.Q = r_q2;
  end else begin : g_noreg
    assign bus.Q = r_q;
  end

  assign bus.INIT_BUSY = w_busy;
endmodule

// File: tb/tb_pa_spsram_param.sv
// tb_pa_spsram_param
// Three instances: A = default geometry, B = 2-group mask + output register +
// non-zero sweep value, C = no sweep, 19-group mask, 64 entries.
// A reference model updates on every clock edge from the bus inputs and queues
// expected read data with its due cycle; a negedge monitor pops and compares Q
// and INIT_BUSY every cycle.
module tb_pa_spsram_param;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  int          DEP [3] = '{512, 512, 64};
  int          GS  [3] = '{1, 19, 2};
  int          ORG [3] = '{0, 1, 0};
  int          IEN [3] = '{1, 1, 0};
  logic [37:0] IV  [3] = '{38'h0, 38'h15_5555_5555, 38'h0};

  logic        cen [3];
  logic        gwen[3];
  logic        req [3];
  logic [37:0] wen [3];
  logic [37:0] d   [3];
  logic [8:0]  a   [3];
  logic [37:0] q   [3];
  logic        busy[3];

  pa_spsram_param_if #(.ADDR_WIDTH(9), .DATA_WIDTH(38), .WE_WIDTH(38)) ifA ();
  pa_spsram_param_if #(.ADDR_WIDTH(9), .DATA_WIDTH(38), .WE_WIDTH(2))  ifB ();
  pa_spsram_param_if #(.ADDR_WIDTH(6), .DATA_WIDTH(38), .WE_WIDTH(19)) ifC ();

  assign ifA.CEN = cen[0]; assign ifA.GWEN = gwen[0]; assign ifA.WEN = wen[0];
  assign ifA.A = a[0]; assign ifA.D = d[0]; assign ifA.INIT_REQ = req[0];
  assign ifB.CEN = cen[1]; assign ifB.GWEN = gwen[1]; assign ifB.WEN = wen[1][1:0];
  assign ifB.A = a[1]; assign ifB.D = d[1]; assign ifB.INIT_REQ = req[1];
  assign ifC.CEN = cen[2]; assign ifC.GWEN = gwen[2]; assign ifC.WEN = wen[2][18:0];
  assign ifC.A = a[2][5:0]; assign ifC.D = d[2]; assign ifC.INIT_REQ = req[2];
  assign q[0] = ifA.Q; assign busy[0] = ifA.INIT_BUSY;
  assign q[1] = ifB.Q; assign busy[1] = ifB.INIT_BUSY;
  assign q[2] = ifC.Q; assign busy[2] = ifC.INIT_BUSY;

  pa_spsram_param #(.ADDR_WIDTH(9), .DATA_WIDTH(38), .WE_WIDTH(38), .OUT_REG(0),
                    .INIT_EN(1), .INIT_VAL(38'h0))
    dutA (.CLK(CLK), .RST(RST), .bus(ifA));
  pa_spsram_param #(.ADDR_WIDTH(9), .DATA_WIDTH(38), .WE_WIDTH(2), .OUT_REG(1),
                    .INIT_EN(1), .INIT_VAL(38'h15_5555_5555))
    dutB (.CLK(CLK), .RST(RST), .bus(ifB));
  pa_spsram_param #(.ADDR_WIDTH(6), .DATA_WIDTH(38), .WE_WIDTH(19), .OUT_REG(0),
                    .INIT_EN(0), .INIT_VAL(38'h0))
    dutC (.CLK(CLK), .RST(RST), .bus(ifC));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [37:0] act, input logic [37:0] exp_);
    checks++;
    if (act !== exp_) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct { int k; logic [37:0] v; int due; } exp_t;
  exp_t        sb[$];
  logic [37:0] mdl [3][512];
  int          left[3];      // sweep cycles still owed; >0 means busy
  int          cyc = 0;
  logic [37:0] exp_q[3] = '{38'h0, 38'h0, 38'h0};

  initial begin
    int aa;
    for (int k = 0; k < 3; k++) left[k] = IEN[k] != 0 ? DEP[k] : 0;
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        for (int k = 0; k < 3; k++) left[k] = IEN[k] != 0 ? DEP[k] : 0;
        sb.delete();
      end else begin
        cyc++;
        for (int k = 0; k < 3; k++) begin
          if (left[k] > 0) begin
            mdl[k][DEP[k] - left[k]] = IV[k];
            left[k]--;
          end else begin
            aa = int'(a[k]) % DEP[k];
            if (!cen[k]) begin
              if (!gwen[k]) begin
                for (int b = 0; b < 38; b++)
                  if (!wen[k][b / GS[k]]) mdl[k][aa][b] = d[k][b];
              end else begin
                sb.push_back('{k, mdl[k][aa], cyc + ORG[k]});
              end
            end
            if (req[k] && IEN[k] != 0) left[k] = DEP[k];
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (RST) for (int k = 0; k < 3; k++) exp_q[k] = '0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].due < cyc) begin
          errors++;
          $display("FAIL stale_read%0d: due %0d now %0d", sb[i].k, sb[i].due, cyc);
          sb.delete(i);
        end else if (sb[i].due == cyc) begin
          exp_q[sb[i].k] = sb[i].v;
          sb.delete(i);
        end
      end
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("q%0d", k), q[k], exp_q[k]);
        chk($sformatf("busy%0d", k), {37'b0, busy[k]}, {37'b0, left[k] > 0});
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [37:0] rnd38();
    logic [63:0] r = {$urandom(), $urandom()};
    return r[37:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge CLK); #2; end
  endtask

  task automatic drv(input int k, input logic c, input logic g, input logic [37:0] w,
                     input logic [8:0] ad, input logic [37:0] dd, input logic r);
    cen[k] = c; gwen[k] = g; wen[k] = w; a[k] = ad; d[k] = dd; req[k] = r;
    tick(1);
    cen[k] = 1'b1; gwen[k] = 1'b1; wen[k] = '1; req[k] = 1'b0;
  endtask

  task automatic wr(input int k, input logic [8:0] ad, input logic [37:0] dd, input logic [37:0] w);
    drv(k, 1'b0, 1'b0, w, ad, dd, 1'b0);
  endtask

  task automatic rd(input int k, input logic [8:0] ad);
    drv(k, 1'b0, 1'b1, '1, ad, '0, 1'b0);
  endtask

  task automatic pulse_req(input int k);
    drv(k, 1'b1, 1'b1, '1, '0, '0, 1'b1);
  endtask

  task automatic wait_ready(input int k);
    int t = 0;
    while (busy[k] && t < 2000) begin tick(1); t++; end
    chk($sformatf("ready%0d", k), {37'b0, busy[k]}, 38'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      cen[k] = 1'b1; gwen[k] = 1'b1; wen[k] = '1; a[k] = '0; d[k] = '0; req[k] = 1'b0;
    end
    #1 RST = 1'b1;
    tick(2);
    RST = 1'b0;

    // C (no sweep): usable on the very first edge, INIT_REQ ignored
    wr(2, 9'd7, 38'h12_3456_789A, '0);
    pulse_req(2);
    rd(2, 9'd7);
    chk("c_first_rw", q[2], 38'h12_3456_789A);
    for (int i = 0; i < 64; i++) wr(2, 9'(i), rnd38(), '0);

    wait_ready(0);
    wait_ready(1);

    // A: swept contents, latency 1
    rd(0, 9'd0);   chk("a_rd0",   q[0], 38'h0);
    rd(0, 9'd255); chk("a_rd255", q[0], 38'h0);
    rd(0, 9'd511); chk("a_rd511", q[0], 38'h0);
    // A: partial-mask write
    wr(0, 9'h05, 38'h3F_FFFF_FFFF, '0);
    wr(0, 9'h05, 38'h0, {30'h3FFF_FFFF, 8'h00});
    rd(0, 9'h05);  chk("a_mask8", q[0], 38'h3F_FFFF_FF00);

    // B: sweep value, 2-group mask, latency 2
    rd(1, 9'd100); chk("b_lat_hold", q[1], 38'h0);
    tick(1);       chk("b_initval", q[1], 38'h15_5555_5555);
    wr(1, 9'd9, 38'h0, '0);
    wr(1, 9'd9, '1, 38'h2);
    rd(1, 9'd9);
    tick(1);       chk("b_grp", q[1], 38'h00_0007_FFFF);
    // B: read then INIT_REQ on the next edge; pipelined result still lands
    wr(1, 9'd9, 38'h0, '0);
    rd(1, 9'd9);
    pulse_req(1);
    chk("b_pipe_thru_init", q[1], 38'h0);
    chk("b_busy_after_req", {37'b0, busy[1]}, 38'h1);
    wait_ready(1);

    // A: re-init while holding Q, busy write ignored
    wr(0, 9'd3, 38'h1234, '0);
    rd(0, 9'd3);   chk("a_rd1234", q[0], 38'h1234);
    pulse_req(0);
    wr(0, 9'd3, 38'hFFFF, '0);
    wait_ready(0);
    chk("a_q_held", q[0], 38'h1234);
    rd(0, 9'd3);   chk("a_cleared", q[0], 38'h0);

    // A: reset 100 cycles into a sweep
    wr(0, 9'd3, 38'h1234, '0);
    rd(0, 9'd3);
    pulse_req(0);
    tick(99);
    RST = 1'b1;
    #1;
    chk("rst_q0", q[0], 38'h0);
    chk("rst_busy0", {37'b0, busy[0]}, 38'h1);
    tick(2);
    RST = 1'b0;
    wait_ready(0);
    wait_ready(1);

    // random traffic on all three instances
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 3; k++) begin
        cen[k]  = ($urandom_range(0, 3) == 0);
        gwen[k] = 1'($urandom_range(0, 1));
        wen[k]  = rnd38();
        a[k]    = 9'($urandom_range(0, 511));
        d[k]    = rnd38();
        req[k]  = ($urandom_range(0, 399) == 0);
      end
      tick(1);
    end
    for (int k = 0; k < 3; k++) begin cen[k] = 1'b1; req[k] = 1'b0; end
    tick(5);
    chk("sb_empty", 38'(sb.size()), 38'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
